// File: rtl/bl_pkg.sv
// Shared types and constants for the backlight zone peak-statistics block.
package bl_pkg;

  localparam int unsigned H_ACT_DFLT   = 1920;
  localparam int unsigned V_ACT_DFLT   = 1080;
  localparam int unsigned ZONES_X_DFLT = 16;
  localparam int unsigned ZONES_Y_DFLT = 8;

  localparam int unsigned ZW       = H_ACT_DFLT / ZONES_X_DFLT;
  localparam int unsigned ZH       = V_ACT_DFLT / ZONES_Y_DFLT;
  localparam int unsigned ZONE_CNT = ZONES_X_DFLT * ZONES_Y_DFLT;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LVL_W  = 8;

  typedef enum logic {StIdle, StSend} stream_state_e;

  function automatic logic [LVL_W-1:0] max8(input logic [LVL_W-1:0] a, input logic [LVL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bl_zone_max_stat_if.sv
// SRAM-writer side of the zone statistics block: frame start, zone word handshake, overflow flag.
interface bl_zone_max_stat_if;
  import bl_pkg::*;

  logic              O_sof;
  logic              O_wr_valid;
  logic              I_wr_ready;
  logic [ADDR_W-1:0] O_wr_addr;
  logic [DATA_W-1:0] O_wr_data;
  logic              O_ovf;

  modport master (
    output O_sof, O_wr_valid, O_wr_addr, O_wr_data, O_ovf,
    input  I_wr_ready
  );

  modport slave (
    input  O_sof, O_wr_valid, O_wr_addr, O_wr_data, O_ovf,
    output I_wr_ready
  );

endinterface

// File: rtl/bl_zone_stream.sv
// Shadow buffer and word streamer for one completed zone row.
// Optional BL_MIN_CLAMP_EN: floor each streamed level at MIN_LEVEL.
module bl_zone_stream
  import bl_pkg::*;
#(
  parameter int unsigned      ZONES_X   = ZONES_X_DFLT,
  parameter logic [LVL_W-1:0] MIN_LEVEL = 8'd16
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_load,
  input  logic [LVL_W-1:0]  I_acc [ZONES_X],
  input  logic [ADDR_W-1:0] I_row,
  output logic              O_idle,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [ADDR_W-1:0] O_addr,
  output logic [DATA_W-1:0] O_data
);

  localparam int unsigned       IdxW    = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam logic [IdxW-1:0]   IdxLast = IdxW'(ZONES_X - 1);
  localparam logic [ADDR_W-1:0] ZonesXA = ADDR_W'(ZONES_X);

  stream_state_e     state_q, state_d;
  logic [IdxW-1:0]   idx_q;
  logic [ADDR_W-1:0] base_q;
  logic [LVL_W-1:0]  shadow_q [ZONES_X];
  logic [LVL_W-1:0]  lvl;
  logic              accept;

  assign accept = (state_q == StSend) && I_ready;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // The load strobe doubles as the pending flag: IDLE consumes it on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (I_load) state_d = StSend;
      StSend:  if (accept && (idx_q == IdxLast)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      idx_q    <= '0;
      base_q   <= '0;
      shadow_q <= '{default: '0};
    end else if (I_load && (state_q == StIdle)) begin
      idx_q    <= '0;
      base_q   <= I_row * ZonesXA;
      shadow_q <= I_acc;
    end else if (accept) begin
      idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    lvl = shadow_q[idx_q];
`ifdef BL_MIN_CLAMP_EN
    lvl = max8(lvl, MIN_LEVEL);
`endif
    O_idle  = (state_q == StIdle);
    O_valid = (state_q == StSend);
    O_addr  = O_valid ? (base_q + ADDR_W'(idx_q)) : '0;
    O_data  = O_valid ? {lvl, lvl} : '0;
  end

`ifndef BL_MIN_CLAMP_EN
  logic unused_min_level;
  assign unused_min_level = ^MIN_LEVEL;
`endif

endmodule

// File: rtl/bl_zone_max_stat.sv
// Per-zone peak max(R,G,B) statistics streamed to the backlight SRAM writer.
// Optional BL_MIN_CLAMP_EN (in bl_zone_stream) floors output levels at MIN_LEVEL.
module bl_zone_max_stat
  import bl_pkg::*;
#(
  parameter int unsigned      H_ACT     = H_ACT_DFLT,
  parameter int unsigned      V_ACT     = V_ACT_DFLT,
  parameter int unsigned      ZONES_X   = ZONES_X_DFLT,
  parameter int unsigned      ZONES_Y   = ZONES_Y_DFLT,
  parameter bit               VS_POL    = 1'b1,
  parameter logic [LVL_W-1:0] MIN_LEVEL = 8'd16
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_vs,
  input  logic              I_de,
  input  logic [LVL_W-1:0]  I_data_r,
  input  logic [LVL_W-1:0]  I_data_g,
  input  logic [LVL_W-1:0]  I_data_b,
  bl_zone_max_stat_if.master wr
);

  localparam int unsigned ZoneW = H_ACT / ZONES_X;
  localparam int unsigned ZoneH = V_ACT / ZONES_Y;
  localparam int unsigned PxW   = $clog2(H_ACT + 1);
  localparam int unsigned ZcW   = $clog2(ZoneW + 1);
  localparam int unsigned ColW  = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam int unsigned LineW = $clog2(V_ACT + 1);
  localparam int unsigned LizW  = $clog2(ZoneH + 1);
  localparam int unsigned RowW  = $clog2(ZONES_Y + 1);

  logic [LVL_W-1:0] lum_q;
  logic             de_q, vs_q, de_prev_q, vs_prev_q;
  logic [PxW-1:0]   px_q;
  logic [ZcW-1:0]   zc_q;
  logic [ColW-1:0]  col_q;
  logic [LineW-1:0] line_q;
  logic [LizW-1:0]  liz_q;
  logic [RowW-1:0]  row_q;
  logic [LVL_W-1:0] acc_q [ZONES_X];
  logic             sof_q, ovf_q;

  logic frame_start, de_fall, line_live, px_live, row_done, stream_idle;

  // Luma stage; de/vs ride along so every zone decision sees aligned signals.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      lum_q     <= '0;
      de_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      lum_q     <= max8(max8(I_data_r, I_data_g), I_data_b);
      de_q      <= I_de;
      vs_q      <= I_vs;
      de_prev_q <= de_q;
      vs_prev_q <= vs_q;
    end
  end

  assign frame_start = (vs_q == VS_POL) && (vs_prev_q != VS_POL);
  assign de_fall     = de_prev_q && !de_q;
  assign line_live   = (line_q < LineW'(V_ACT));
  assign px_live     = de_q && (px_q < PxW'(H_ACT));
  assign row_done    = de_fall && line_live && (liz_q == LizW'(ZoneH - 1)) &&
                       (row_q < RowW'(ZONES_Y));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      px_q   <= '0;
      zc_q   <= '0;
      col_q  <= '0;
      line_q <= '0;
      liz_q  <= '0;
      row_q  <= '0;
      acc_q  <= '{default: '0};
    end else if (frame_start) begin
      px_q   <= '0;
      zc_q   <= '0;
      col_q  <= '0;
      line_q <= '0;
      liz_q  <= '0;
      row_q  <= '0;
      acc_q  <= '{default: '0};
    end else begin
      if (px_live) begin
        acc_q[col_q] <= max8(acc_q[col_q], lum_q);
        px_q         <= px_q + 1'b1;
        if (zc_q == ZcW'(ZoneW - 1)) begin
          zc_q  <= '0;
          col_q <= col_q + 1'b1;
        end else begin
          zc_q <= zc_q + 1'b1;
        end
      end
      if (de_fall) begin
        px_q  <= '0;
        zc_q  <= '0;
        col_q <= '0;
        if (line_live) begin
          line_q <= line_q + 1'b1;
          liz_q  <= (liz_q == LizW'(ZoneH - 1)) ? '0 : liz_q + 1'b1;
        end
        // Accumulators restart whether the row was handed off or dropped.
        if (row_done) begin
          acc_q <= '{default: '0};
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sof_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sof_q <= frame_start;
      ovf_q <= ovf_q | (row_done & ~stream_idle);
    end
  end

  bl_zone_stream #(
    .ZONES_X  (ZONES_X),
    .MIN_LEVEL(MIN_LEVEL)
  ) u_stream (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_load (row_done && stream_idle),
    .I_acc  (acc_q),
    .I_row  (ADDR_W'(row_q)),
    .O_idle (stream_idle),
    .O_valid(wr.O_wr_valid),
    .I_ready(wr.I_wr_ready),
    .O_addr (wr.O_wr_addr),
    .O_data (wr.O_wr_data)
  );

  assign wr.O_sof = sof_q;
  assign wr.O_ovf = ovf_q;

endmodule

// File: tb/tb_bl_zone_max_stat.sv
// Directed bench for bl_zone_max_stat on an 8x4 frame split into 2x2 zones.
module tb_bl_zone_max_stat;

  logic       I_clk = 1'b0;
  logic       I_rst_n;
  logic       I_vs;
  logic       I_de;
  logic [7:0] I_data_r, I_data_g, I_data_b;

  bl_zone_max_stat_if wr();

  bl_zone_max_stat #(
    .H_ACT    (8),
    .V_ACT    (4),
    .ZONES_X  (2),
    .ZONES_Y  (2),
    .VS_POL   (1'b1),
    .MIN_LEVEL(8'd16)
  ) dut (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_vs    (I_vs),
    .I_de    (I_de),
    .I_data_r(I_data_r),
    .I_data_g(I_data_g),
    .I_data_b(I_data_b),
    .wr      (wr)
  );

  always #5 I_clk = ~I_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fall_cyc = 0;
  int          rise_cyc = -1;
  logic        valid_prev = 1'b0;
  logic [9:0]  q_addr[$];
  logic [15:0] q_data[$];
  logic [9:0]  ea [4];
  logic [15:0] ed [4];

  always @(posedge I_clk) cyc <= cyc + 1;

  // Observe away from the edge; an accept happens when valid && ready hold at the next posedge.
  always @(negedge I_clk) begin
    if (wr.O_wr_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = wr.O_wr_valid;
    if (I_rst_n && wr.O_wr_valid && wr.I_wr_ready) begin
      q_addr.push_back(wr.O_wr_addr);
      q_data.push_back(wr.O_wr_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic [7:0] v);
    logic [7:0] l;
    l = v;
`ifdef BL_MIN_CLAMP_EN
    if (l < 8'd16) l = 8'd16;
`endif
    return {l, l};
  endfunction

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic drive_line(input int hot, input logic [7:0] hr, input logic [7:0] hg,
                            input logic [7:0] hb);
    for (int i = 0; i < 8; i++) begin
      I_de = 1'b1;
      {I_data_r, I_data_g, I_data_b} = (i == hot) ? {hr, hg, hb} : 24'h0;
      tick();
    end
    I_de = 1'b0;
    {I_data_r, I_data_g, I_data_b} = 24'h0;
    fall_cyc = cyc;
    repeat (3) tick();
  endtask

  task automatic vs_pulse(input string tag);
    logic [3:0] seen;
    I_vs = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge I_clk);
      seen[k] = wr.O_sof;
    end
    check_eq(tag, {28'h0, seen}, 32'h4);
    tick();
    I_vs = 1'b0;
    tick();
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic check_q(input string tag, input int n_exp);
    check_eq({tag, "_count"}, q_addr.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), {22'h0, q_addr[i]}, {22'h0, ea[i]});
      check_eq($sformatf("%s_data%0d", tag, i), {16'h0, q_data[i]}, {16'h0, ed[i]});
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!wr.O_wr_valid && n < 20) begin
      @(negedge I_clk);
      n++;
    end
    check_eq(tag, {31'h0, wr.O_wr_valid}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_rst_n = 1'b0;
    I_vs = 1'b0;
    I_de = 1'b0;
    {I_data_r, I_data_g, I_data_b} = 24'h0;
    wr.I_wr_ready = 1'b1;
    repeat (3) tick();

    check_eq("rst_sof",   {31'h0, wr.O_sof},      32'h0);
    check_eq("rst_valid", {31'h0, wr.O_wr_valid}, 32'h0);
    check_eq("rst_addr",  {22'h0, wr.O_wr_addr},  32'h0);
    check_eq("rst_data",  {16'h0, wr.O_wr_data},  32'h0);
    check_eq("rst_ovf",   {31'h0, wr.O_ovf},      32'h0);
    I_rst_n = 1'b1;
    repeat (2) tick();

    // Frame start then basic peak per zone
    vs_pulse("sof_basic");
    check_eq("sof_no_valid", {31'h0, wr.O_wr_valid}, 32'h0);
    clear_q();
    rise_cyc = -1;
    drive_line(2, 8'd200, 8'd0, 8'd0);
    drive_line(5, 8'd0, 8'd90, 8'd0);
    check_eq("lat_row0", rise_cyc - fall_cyc, 32'd2);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    repeat (4) tick();
    ea = '{10'd0, 10'd1, 10'd2, 10'd3};
    ed = '{word(8'hC8), word(8'h5A), word(8'h00), word(8'h00)};
    check_q("basic", 4);

    // Backpressure holds addr/data stable
    vs_pulse("sof_bp");
    clear_q();
    wr.I_wr_ready = 1'b0;
    drive_line(0, 8'd10, 8'd0, 8'd0);
    drive_line(4, 8'd0, 8'd0, 8'd20);
    for (int k = 0; k < 5; k++) begin
      @(negedge I_clk);
      check_eq($sformatf("bp_valid%0d", k), {31'h0, wr.O_wr_valid}, 32'h1);
      check_eq($sformatf("bp_addr%0d", k),  {22'h0, wr.O_wr_addr},  32'h0);
      check_eq($sformatf("bp_data%0d", k),  {16'h0, wr.O_wr_data},  {16'h0, word(8'h0A)});
    end
    tick();
    wr.I_wr_ready = 1'b1;
    repeat (2) tick();
    check_eq("bp_idle", {31'h0, wr.O_wr_valid}, 32'h0);
    ea[0] = 10'd0; ed[0] = word(8'h0A);
    ea[1] = 10'd1; ed[1] = word(8'h14);
    check_q("bp", 2);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    repeat (4) tick();

    // Row 1 completes while row 0 is still stalled
    vs_pulse("sof_ovf");
    check_eq("ovf_clear", {31'h0, wr.O_ovf}, 32'h0);
    clear_q();
    wr.I_wr_ready = 1'b0;
    drive_line(7, 8'h33, 8'd0, 8'd0);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    check_eq("ovf_set", {31'h0, wr.O_ovf}, 32'h1);
    wr.I_wr_ready = 1'b1;
    repeat (6) tick();
    ea[0] = 10'd0; ed[0] = word(8'h00);
    ea[1] = 10'd1; ed[1] = word(8'h33);
    check_q("ovf", 2);
    vs_pulse("sof_ovf2");
    check_eq("ovf_sticky", {31'h0, wr.O_ovf}, 32'h1);

    // Reset while the second word of a row is on the bus
    clear_q();
    wr.I_wr_ready = 1'b0;
    drive_line(1, 8'h77, 8'd0, 8'd0);
    drive_line(6, 8'd0, 8'h44, 8'd0);
    wait_valid("rst_wait_valid");
    tick();
    wr.I_wr_ready = 1'b1;
    tick();
    wr.I_wr_ready = 1'b0;
    @(negedge I_clk);
    check_eq("pre_rst_addr", {22'h0, wr.O_wr_addr}, 32'h1);
    check_eq("pre_rst_data", {16'h0, wr.O_wr_data}, {16'h0, word(8'h44)});
    #2;
    I_rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'h0, wr.O_wr_valid}, 32'h0);
    check_eq("arst_addr",  {22'h0, wr.O_wr_addr},  32'h0);
    check_eq("arst_data",  {16'h0, wr.O_wr_data},  32'h0);
    check_eq("arst_ovf",   {31'h0, wr.O_ovf},      32'h0);
    tick();
    I_rst_n = 1'b1;
    wr.I_wr_ready = 1'b1;
    tick();
    vs_pulse("sof_after_rst");
    clear_q();
    drive_line(3, 8'd0, 8'd0, 8'd5);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    drive_line(-1, 8'd0, 8'd0, 8'd0);
    repeat (4) tick();
    ea = '{10'd0, 10'd1, 10'd2, 10'd3};
    ed = '{word(8'h05), word(8'h00), word(8'h00), word(8'h00)};
    check_q("post_rst", 4);

    // All-black frame: clamp floor or true black depending on build
    vs_pulse("sof_black");
    clear_q();
    for (int l = 0; l < 4; l++) drive_line(-1, 8'd0, 8'd0, 8'd0);
    repeat (4) tick();
    ed = '{word(8'h00), word(8'h00), word(8'h00), word(8'h00)};
    check_q("black", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
